// File: rtl/time_pkg.sv
// Shared field layout, limits and calendar helper for the timekeeping core.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package time_pkg;

  // Time word: hour[16:12] min[11:6] sec[5:0]
  localparam int HOUR_HI  = 16;
  localparam int HOUR_LO  = 12;
  localparam int MIN_HI   = 11;
  localparam int MIN_LO   = 6;
  localparam int SEC_HI   = 5;
  localparam int SEC_LO   = 0;

  // Date word: year[15:9] month[8:5] day[4:0]
  localparam int YEAR_HI  = 15;
  localparam int YEAR_LO  = 9;
  localparam int MONTH_HI = 8;
  localparam int MONTH_LO = 5;
  localparam int DAY_HI   = 4;
  localparam int DAY_LO   = 0;

  localparam logic [4:0] HOUR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX   = 6'd59;
  localparam logic [6:0] YEAR_MAX  = 7'd99;
  localparam logic [3:0] MONTH_MAX = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_CLR = 2'd2
  } commit_state_t;

  // Two-digit year: every year divisible by four is a leap year.
  function automatic logic [4:0] days_in_month(input logic [6:0] year,
                                               input logic [3:0] month);
    logic [4:0] d;
    case (month)
      4'd2:                    d = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: emits a single-cycle tick every CLK_HZ unfrozen cycles.
// Latency: tick is asserted during the cycle the count sits at CLK_HZ-1.
// Backpressure: freeze holds the count (no tick); clear forces it to 0 (no tick).
// Ports: CLK, RESETN (async, active-low), freeze, clear -> tick.
module tick_gen #(
  parameter int CLK_HZ = 1000000
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic freeze,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;
  logic          terminal;

  assign terminal = (cnt_q == TERM);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (!freeze) begin
      cnt_q <= terminal ? '0 : cnt_q + CW'(1);
    end
  end

  // A clear coincides with a load in the parent; the load wins, so the tick
  // is dropped here rather than leaking into the counters.
  assign tick = terminal && !freeze && !clear;

endmodule

// File: rtl/time_keeper.sv
// Time-of-day/calendar counters, commit handshake for edited values, and alarm.
// Latency: loads and ticks visible one cycle after the sampling edge.
// Backpressure: requests are level; held requests are ignored until dropped.
// Ports: CLK, RESETN, MODE[0]=freeze, SETTING/ALARM_SETTING commit requests
//        with SET_TIME/SET_DATE/SET_ALARM_TIME, ALARM_ENABLE ->
//        IN_TIME, IN_DATE, IN_ALARM_TIME, SETTING_OK, ALARM_RING.
module time_keeper
  import time_pkg::*;
#(
  parameter int CLK_HZ       = 1000000,
  parameter int RING_SECONDS = 60
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [5:0]  MODE,
  input  logic        SETTING,
  input  logic        ALARM_SETTING,
  input  logic [16:0] SET_TIME,
  input  logic [15:0] SET_DATE,
  input  logic [16:0] SET_ALARM_TIME,
  input  logic        ALARM_ENABLE,
  output logic [16:0] IN_TIME,
  output logic [15:0] IN_DATE,
  output logic [16:0] IN_ALARM_TIME,
  output logic        SETTING_OK,
  output logic        ALARM_RING
);

  localparam int RCW = ($clog2(RING_SECONDS + 1) > 0) ? $clog2(RING_SECONDS + 1) : 1;
  localparam logic [RCW-1:0] RING_LOAD = RCW'(RING_SECONDS);

  // Only the freeze bit of the controller mode matters here.
  logic unused_mode_bits;
  assign unused_mode_bits = ^MODE[5:1];

  function automatic logic [16:0] clamp_time(input logic [16:0] t);
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    h = t[HOUR_HI:HOUR_LO];
    m = t[MIN_HI:MIN_LO];
    s = t[SEC_HI:SEC_LO];
    if (h > HOUR_MAX) h = HOUR_MAX;
    if (m > MIN_MAX)  m = MIN_MAX;
    if (s > MIN_MAX)  s = MIN_MAX;
    return {h, m, s};
  endfunction

  // ---------------------------------------------------------------- state
  logic [4:0]    hour_q, nx_hour;
  logic [5:0]    min_q,  nx_min;
  logic [5:0]    sec_q,  nx_sec;
  logic [6:0]    year_q, nx_year;
  logic [3:0]    month_q, nx_month;
  logic [4:0]    day_q,  nx_day;
  logic [16:0]   alarm_q;
  logic          ring_q;
  logic [RCW-1:0] ring_cnt_q;
  logic          setting_ok_q;
  commit_state_t state_q, state_nx;

  logic tick;
  logic load_time;
  logic load_alarm;

  // ---------------------------------------------------------------- prescaler
  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .CLK    (CLK),
    .RESETN (RESETN),
    .freeze (MODE[0]),
    .clear  (load_time),
    .tick   (tick)
  );

  // ---------------------------------------------------------------- commit FSM
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:     if (SETTING || ALARM_SETTING)   state_nx = ST_ACK;
      ST_ACK:                                      state_nx = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!SETTING && !ALARM_SETTING) state_nx = ST_IDLE;
      default:                                     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    load_time  = (state_q == ST_IDLE) && SETTING;
    load_alarm = (state_q == ST_IDLE) && ALARM_SETTING;
  end

  // Acknowledge flop rises with the load edge, so it covers exactly the ACK cycle.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      setting_ok_q <= 1'b0;
    end else begin
      setting_ok_q <= load_time || load_alarm;
    end
  end

  // ---------------------------------------------------------------- load sanitising
  logic [16:0] ld_time;
  logic [6:0]  ld_year;
  logic [3:0]  ld_month;
  logic [4:0]  ld_day;
  logic [4:0]  ld_dim;

  always_comb begin
    ld_time  = clamp_time(SET_TIME);
    ld_year  = SET_DATE[YEAR_HI:YEAR_LO];
    ld_month = SET_DATE[MONTH_HI:MONTH_LO];
    ld_day   = SET_DATE[DAY_HI:DAY_LO];
    if (ld_year > YEAR_MAX)   ld_year  = YEAR_MAX;
    if (ld_month == 4'd0)     ld_month = 4'd1;
    if (ld_month > MONTH_MAX) ld_month = MONTH_MAX;
    // Day limit follows the already-clamped year and month.
    ld_dim = days_in_month(ld_year, ld_month);
    if (ld_day == 5'd0)       ld_day   = 5'd1;
    if (ld_day > ld_dim)      ld_day   = ld_dim;
  end

  // ---------------------------------------------------------------- tick carry chain
  always_comb begin
    nx_hour  = hour_q;
    nx_min   = min_q;
    nx_sec   = sec_q;
    nx_year  = year_q;
    nx_month = month_q;
    nx_day   = day_q;
    if (sec_q >= MIN_MAX) begin
      nx_sec = 6'd0;
      if (min_q >= MIN_MAX) begin
        nx_min = 6'd0;
        if (hour_q >= HOUR_MAX) begin
          nx_hour = 5'd0;
          if (day_q >= days_in_month(year_q, month_q)) begin
            nx_day = 5'd1;
            if (month_q >= MONTH_MAX) begin
              nx_month = 4'd1;
              nx_year  = (year_q >= YEAR_MAX) ? 7'd0 : year_q + 7'd1;
            end else begin
              nx_month = month_q + 4'd1;
            end
          end else begin
            nx_day = day_q + 5'd1;
          end
        end else begin
          nx_hour = hour_q + 5'd1;
        end
      end else begin
        nx_min = min_q + 6'd1;
      end
    end else begin
      nx_sec = sec_q + 6'd1;
    end
  end

  // tick is already suppressed by tick_gen whenever load_time clears it.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      year_q  <= 7'd0;
      month_q <= 4'd1;
      day_q   <= 5'd1;
    end else if (load_time) begin
      hour_q  <= ld_time[HOUR_HI:HOUR_LO];
      min_q   <= ld_time[MIN_HI:MIN_LO];
      sec_q   <= ld_time[SEC_HI:SEC_LO];
      year_q  <= ld_year;
      month_q <= ld_month;
      day_q   <= ld_day;
    end else if (tick) begin
      hour_q  <= nx_hour;
      min_q   <= nx_min;
      sec_q   <= nx_sec;
      year_q  <= nx_year;
      month_q <= nx_month;
      day_q   <= nx_day;
    end
  end

  // ---------------------------------------------------------------- alarm
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      alarm_q <= 17'd0;
    end else if (load_alarm) begin
      alarm_q <= clamp_time(SET_ALARM_TIME);
    end
  end

  // Only ticks can trigger: a commit landing on the alarm time is silent.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else if (!ALARM_ENABLE) begin
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else if (tick) begin
      if ({nx_hour, nx_min, nx_sec} == alarm_q) begin
        ring_q     <= 1'b1;
        ring_cnt_q <= RING_LOAD;
      end else if (ring_q) begin
        if (ring_cnt_q <= RCW'(1)) begin
          ring_q     <= 1'b0;
          ring_cnt_q <= '0;
        end else begin
          ring_cnt_q <= ring_cnt_q - RCW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign IN_TIME       = {hour_q, min_q, sec_q};
  assign IN_DATE       = {year_q, month_q, day_q};
  assign IN_ALARM_TIME = alarm_q;
  assign SETTING_OK    = setting_ok_q;
  assign ALARM_RING    = ring_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with a 4-cycle second and a 3-second ring.
// Latency: inputs driven on negedges, outputs sampled on negedges.
// Backpressure: n/a.
module tb_time_keeper;

  logic        CLK;
  logic        RESETN;
  logic [5:0]  MODE;
  logic        SETTING;
  logic        ALARM_SETTING;
  logic [16:0] SET_TIME;
  logic [15:0] SET_DATE;
  logic [16:0] SET_ALARM_TIME;
  logic        ALARM_ENABLE;
  logic [16:0] IN_TIME;
  logic [15:0] IN_DATE;
  logic [16:0] IN_ALARM_TIME;
  logic        SETTING_OK;
  logic        ALARM_RING;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  time_keeper #(
    .CLK_HZ       (4),
    .RING_SECONDS (3)
  ) dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .MODE           (MODE),
    .SETTING        (SETTING),
    .ALARM_SETTING  (ALARM_SETTING),
    .SET_TIME       (SET_TIME),
    .SET_DATE       (SET_DATE),
    .SET_ALARM_TIME (SET_ALARM_TIME),
    .ALARM_ENABLE   (ALARM_ENABLE),
    .IN_TIME        (IN_TIME),
    .IN_DATE        (IN_DATE),
    .IN_ALARM_TIME  (IN_ALARM_TIME),
    .SETTING_OK     (SETTING_OK),
    .ALARM_RING     (ALARM_RING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [16:0] mk_t(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [15:0] mk_d(input int y, input int mo, input int d);
    return {7'(y), 4'(mo), 5'(d)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Time/date commit; returns at the negedge just after the load edge.
  task automatic load(input logic [16:0] t, input logic [15:0] d);
    SET_TIME = t;
    SET_DATE = d;
    SETTING  = 1'b1;
    @(negedge CLK);
    SETTING  = 1'b0;
    check("ack", 32'(SETTING_OK), 32'd1);
  endtask

  initial begin
    RESETN = 1'b0; MODE = 6'd0; SETTING = 1'b0; ALARM_SETTING = 1'b0;
    SET_TIME = '0; SET_DATE = '0; SET_ALARM_TIME = '0; ALARM_ENABLE = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_time",  32'(IN_TIME),       32'(mk_t(0, 0, 0)));
    check("rst_date",  32'(IN_DATE),       32'(mk_d(0, 1, 1)));
    check("rst_alarm", 32'(IN_ALARM_TIME), 32'd0);
    check("rst_ok",    32'(SETTING_OK),    32'd0);
    check("rst_ring",  32'(ALARM_RING),    32'd0);
    RESETN = 1'b1;
    @(negedge CLK);

    // Full rollover
    load(mk_t(23, 59, 59), mk_d(99, 12, 31));
    check("roll_ld_time", 32'(IN_TIME), 32'(mk_t(23, 59, 59)));
    check("roll_ld_date", 32'(IN_DATE), 32'(mk_d(99, 12, 31)));
    repeat (3) @(negedge CLK);
    check("roll_pre_tick", 32'(IN_TIME), 32'(mk_t(23, 59, 59)));
    check("roll_ok_low",   32'(SETTING_OK), 32'd0);
    @(negedge CLK);
    check("roll_time", 32'(IN_TIME), 32'(mk_t(0, 0, 0)));
    check("roll_date", 32'(IN_DATE), 32'(mk_d(0, 1, 1)));

    // Leap / non-leap February
    load(mk_t(23, 59, 59), mk_d(4, 2, 28));
    repeat (4) @(negedge CLK);
    check("leap_date", 32'(IN_DATE), 32'(mk_d(4, 2, 29)));
    load(mk_t(23, 59, 59), mk_d(5, 2, 28));
    repeat (4) @(negedge CLK);
    check("nonleap_date", 32'(IN_DATE), 32'(mk_d(5, 3, 1)));

    // Handshake: request held for many cycles yields one pulse
    SET_TIME = mk_t(12, 34, 56);
    SET_DATE = mk_d(24, 6, 15);
    SETTING  = 1'b1;
    pulses   = 0;
    @(negedge CLK);
    check("hs_ok",   32'(SETTING_OK), 32'd1);
    check("hs_time", 32'(IN_TIME), 32'(mk_t(12, 34, 56)));
    check("hs_date", 32'(IN_DATE), 32'(mk_d(24, 6, 15)));
    if (SETTING_OK) pulses++;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (SETTING_OK) pulses++;
    end
    check("hs_one_pulse", 32'(pulses), 32'd1);
    SETTING = 1'b0;
    repeat (2) @(negedge CLK);
    load(mk_t(1, 2, 3), mk_d(24, 6, 15));
    check("hs_reload_time", 32'(IN_TIME), 32'(mk_t(1, 2, 3)));
    repeat (2) @(negedge CLK);

    // Sanitising
    load(mk_t(0, 0, 0), 16'd0);
    check("san_zero_date", 32'(IN_DATE), 32'(mk_d(0, 1, 1)));
    repeat (2) @(negedge CLK);
    load(mk_t(0, 0, 0), mk_d(1, 2, 31));
    check("san_feb31", 32'(IN_DATE), 32'(mk_d(1, 2, 28)));
    repeat (2) @(negedge CLK);
    load(mk_t(31, 63, 62), mk_d(127, 15, 31));
    check("san_time", 32'(IN_TIME), 32'(mk_t(23, 59, 59)));
    check("san_date", 32'(IN_DATE), 32'(mk_d(99, 12, 31)));
    repeat (2) @(negedge CLK);

    // Freeze: prescaler holds its count, then resumes from it
    load(mk_t(10, 0, 0), mk_d(24, 6, 15));
    repeat (2) @(negedge CLK);
    MODE = 6'd1;
    repeat (12) @(negedge CLK);
    check("frz_hold", 32'(IN_TIME), 32'(mk_t(10, 0, 0)));
    MODE = 6'd0;
    @(negedge CLK);
    check("frz_resume_pre", 32'(IN_TIME), 32'(mk_t(10, 0, 0)));
    @(negedge CLK);
    check("frz_resume_tick", 32'(IN_TIME), 32'(mk_t(10, 0, 1)));
    repeat (2) @(negedge CLK);

    // Alarm: both requests in one cycle
    ALARM_ENABLE   = 1'b1;
    SET_TIME       = mk_t(0, 0, 4);
    SET_DATE       = mk_d(0, 1, 1);
    SET_ALARM_TIME = mk_t(0, 0, 5);
    SETTING        = 1'b1;
    ALARM_SETTING  = 1'b1;
    @(negedge CLK);
    SETTING        = 1'b0;
    ALARM_SETTING  = 1'b0;
    check("al_both_ok",   32'(SETTING_OK), 32'd1);
    check("al_both_time", 32'(IN_TIME), 32'(mk_t(0, 0, 4)));
    check("al_both_alarm", 32'(IN_ALARM_TIME), 32'(mk_t(0, 0, 5)));
    repeat (3) @(negedge CLK);
    check("al_pre", 32'(ALARM_RING), 32'd0);
    @(negedge CLK);
    check("al_match_time", 32'(IN_TIME), 32'(mk_t(0, 0, 5)));
    check("al_ring_on", 32'(ALARM_RING), 32'd1);
    repeat (4) @(negedge CLK);
    check("al_ring_t1", 32'(ALARM_RING), 32'd1);
    repeat (4) @(negedge CLK);
    check("al_ring_t2", 32'(ALARM_RING), 32'd1);
    repeat (4) @(negedge CLK);
    check("al_ring_off", 32'(ALARM_RING), 32'd0);

    // Commit exactly onto the alarm time does not ring
    load(mk_t(0, 0, 5), mk_d(0, 1, 1));
    check("al_commit_silent", 32'(ALARM_RING), 32'd0);
    repeat (4) @(negedge CLK);
    check("al_commit_next", 32'(ALARM_RING), 32'd0);

    // Disable while ringing
    load(mk_t(0, 0, 4), mk_d(0, 1, 1));
    repeat (4) @(negedge CLK);
    check("al_rerun_on", 32'(ALARM_RING), 32'd1);
    ALARM_ENABLE = 1'b0;
    @(negedge CLK);
    check("al_disable_off", 32'(ALARM_RING), 32'd0);
    ALARM_ENABLE = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset while ringing clears immediately
    load(mk_t(0, 0, 4), mk_d(0, 1, 1));
    repeat (4) @(negedge CLK);
    check("al_rst_pre", 32'(ALARM_RING), 32'd1);
    #2 RESETN = 1'b0;
    #1;
    check("al_rst_ring",  32'(ALARM_RING), 32'd0);
    check("al_rst_time",  32'(IN_TIME), 32'(mk_t(0, 0, 0)));
    check("al_rst_alarm", 32'(IN_ALARM_TIME), 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset during ACK: no acknowledge after release
    SET_TIME = mk_t(1, 1, 1);
    SETTING  = 1'b1;
    @(posedge CLK);
    #1;
    check("mid_ack_ok", 32'(SETTING_OK), 32'd1);
    RESETN = 1'b0;
    #1;
    check("mid_ack_rst_ok",   32'(SETTING_OK), 32'd0);
    check("mid_ack_rst_time", 32'(IN_TIME), 32'(mk_t(0, 0, 0)));
    SETTING = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (SETTING_OK) pulses++;
    end
    check("mid_ack_no_pulse", 32'(pulses), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
